mem_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Passes non-memory results straight through to writeback.
- Performs loads and stores on the data-memory port using a req/ack handshake.
- Asserts stall_request while an access is outstanding.

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline.
// Non-memory results from EX/MEM pass straight through to MEM/WB. Loads and
// stores go out on a registered req/ack data-memory port. stall_request holds
// the upstream pipeline while an access is outstanding.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   mem_write_enable/addr/data   register write request from EX/MEM
//   mem_op                       0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW,
//                                6 SB, 7 SH, 8 SW, 9-15 none
//   mem_addr, mem_store_data     effective byte address, store source value
//   dmem_req/we/addr/wdata/sel   registered request to data memory
//   dmem_ack, dmem_rdata         one-cycle completion pulse and read word
//   wb_write_enable/addr/data    to MEM/WB
//   stall_request                hold PC/IF/ID/EX/EX-MEM registers
//   bus_error                    one-cycle pulse: misaligned access or timeout
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_write_enable,
    input  logic [4:0]  mem_write_addr,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_sel,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_write_enable,
    output logic [4:0]  wb_write_addr,
    output logic [31:0] wb_write_data,
    output logic        stall_request,
    output logic        bus_error
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] timeout_cnt;
    logic             err_flag;
    logic [31:0]      load_data_p1;

    logic is_load, is_store, is_mem, is_byte, is_half, is_word, misaligned;

    // Byte enables: little-endian, lane i covers bits 8i+7:8i.
    function automatic logic [3:0] lane_sel(input logic byte_acc, input logic half_acc,
                                            input logic [1:0] off);
        if (byte_acc)      return 4'b0001 << off;
        else if (half_acc) return 4'b0011 << off;
        else               return 4'b1111;
    endfunction

    // Store data is replicated across every lane so the memory only needs
    // to honour dmem_sel.
    function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Select the addressed lane(s) of the captured word and extend.
    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        sb = w[8*off +: 8];
        sh = off[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   begin sx = 32'(sb); return sx; end
            OP_LBU:  return {24'd0, sb};
            OP_LH:   begin sx = 32'(sh); return sx; end
            OP_LHU:  return {16'd0, sh};
            default: return w;
        endcase
    endfunction

    always_comb begin
        is_load    = (mem_op >= OP_LB) && (mem_op <= OP_LW);
        is_store   = (mem_op >= OP_SB) && (mem_op <= OP_SW);
        is_mem     = is_load || is_store;
        is_byte    = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
        is_half    = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
        is_word    = (mem_op == OP_LW) || (mem_op == OP_SW);
        misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
    end

    // Request issue / completion / timeout
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timeout_cnt  <= '0;
            err_flag     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_sel     <= '0;
            load_data_p1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem && !misaligned) begin
                        state       <= REQ;
                        dmem_req    <= 1'b1;
                        dmem_we     <= is_store;
                        dmem_addr   <= {mem_addr[31:2], 2'b00};
                        dmem_sel    <= lane_sel(is_byte, is_half, mem_addr[1:0]);
                        dmem_wdata  <= store_lanes(mem_op, mem_store_data);
                        timeout_cnt <= '0;
                    end
                end
                REQ: begin
                    // An ack on the final timeout cycle still completes normally.
                    if (dmem_ack) begin
                        load_data_p1 <= dmem_rdata;
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        timeout_cnt  <= '0;
                        state        <= DONE;
                    end else if (timeout_cnt == CNT_LAST) begin
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        err_flag    <= 1'b1;
                        timeout_cnt <= '0;
                        state       <= DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                DONE: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writeback / stall / error outputs
    always_comb begin
        wb_write_enable = 1'b0;
        wb_write_data   = mem_write_data;
        stall_request   = 1'b0;
        bus_error       = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    if (misaligned) bus_error     = 1'b1;
                    else            stall_request = 1'b1;
                end else begin
                    wb_write_enable = mem_write_enable;
                end
            end
            REQ: stall_request = 1'b1;
            DONE: begin
                if (err_flag) begin
                    bus_error = 1'b1;
                end else if (is_load) begin
                    wb_write_enable = mem_write_enable;
                    wb_write_data   = load_extract(mem_op, mem_addr[1:0], load_data_p1);
                end
            end
            default: ;
        endcase
    end

    assign wb_write_addr = mem_write_addr;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Each transaction task drives the
// EX/MEM inputs and the memory response cycle by cycle and publishes the
// outputs expected for that cycle; one compare process checks them on every
// falling edge.
module tb_mem_stage;

    localparam int TMO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write_enable = 1'b0;
    logic [4:0]  mem_write_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [3:0]  mem_op = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_store_data = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_sel;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_write_enable;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        stall_request, bus_error;

    mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_store_data(mem_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_sel(dmem_sel), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
        .wb_write_data(wb_write_data), .stall_request(stall_request),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Expected outputs for the current cycle.
    logic        e_on = 1'b0;
    logic        e_stall, e_berr, e_wbwe, e_req, e_we;
    logic [31:0] e_wbdata, e_addr, e_wdata;
    logic [3:0]  e_sel;
    logic        c_wbdata, c_bus, c_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (e_on) begin
            check("stall_request", 32'(stall_request), 32'(e_stall));
            check("bus_error", 32'(bus_error), 32'(e_berr));
            check("wb_write_enable", 32'(wb_write_enable), 32'(e_wbwe));
            check("wb_write_addr", 32'(wb_write_addr), 32'(mem_write_addr));
            check("dmem_req", 32'(dmem_req), 32'(e_req));
            check("dmem_we", 32'(dmem_we), 32'(e_we));
            if (c_wbdata) check("wb_write_data", wb_write_data, e_wbdata);
            if (c_bus) begin
                check("dmem_addr", dmem_addr, e_addr);
                check("dmem_sel", 32'(dmem_sel), 32'(e_sel));
            end
            if (c_wdata) check("dmem_wdata", dmem_wdata, e_wdata);
        end
    end

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] a);
        int off = int'(a % 4);
        if (op == 1 || op == 2 || op == 6) return 4'(1 << off);
        if (op == 3 || op == 4 || op == 7) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        if (op == 6) return (d & 32'hFF) * 32'h01010101;
        if (op == 7) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v = w >> (8 * (a % 4));
        case (op)
            1: begin v = v & 32'hFF;   if (v >= 128)   v = v - 256;   end
            2: v = v & 32'hFF;
            3: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            4: v = v & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_exp(input logic st, input logic be, input logic we_wb,
                           input logic rq, input logic dw);
        e_on = 1'b1; e_stall = st; e_berr = be; e_wbwe = we_wb; e_req = rq; e_we = dw;
        c_wbdata = 1'b0; c_bus = 1'b0; c_wdata = 1'b0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic we, input logic [4:0] wa,
                             input logic [31:0] d);
        mem_op = op; mem_write_enable = we; mem_write_addr = wa; mem_write_data = d;
        mem_addr = 32'h0000_0003; dmem_ack = 1'b0;
        set_exp(1'b0, 1'b0, we, 1'b0, 1'b0);
        c_wbdata = 1'b1; e_wbdata = d;
        tick();
    endtask

    task automatic do_misaligned(input logic [3:0] op, input logic [31:0] a);
        mem_op = op; mem_addr = a; mem_write_enable = 1'b1; mem_write_addr = 5'd7;
        dmem_ack = 1'b0;
        set_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // wait_n: REQ cycles without ack before the ack cycle; timeout: never ack.
    task automatic do_mem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic we, input logic [4:0] wa, input int wait_n,
                          input logic [31:0] rd, input logic [3:0] x_sel,
                          input logic [31:0] x_wdata, input logic [31:0] x_data,
                          input logic timeout);
        logic st = (op >= 6);
        int   n  = timeout ? TMO : wait_n + 1;
        mem_op = op; mem_addr = a; mem_store_data = sd; mem_write_enable = we;
        mem_write_addr = wa; mem_write_data = 32'h5A5A_0000 | 32'(wa);
        dmem_ack = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < n; i++) begin
            dmem_ack   = !timeout && (i == wait_n);
            dmem_rdata = dmem_ack ? rd : 32'hDEAD_BEEF;
            set_exp(1'b1, 1'b0, 1'b0, 1'b1, st);
            c_bus = 1'b1; e_addr = a & 32'hFFFF_FFFC; e_sel = x_sel;
            c_wdata = st; e_wdata = x_wdata;
            tick();
        end
        dmem_ack = 1'b0;
        set_exp(1'b0, timeout, (!timeout && !st) ? we : 1'b0, 1'b0, 1'b0);
        c_wbdata = !timeout && !st && we; e_wbdata = x_data;
        tick();
    endtask

    task automatic do_mem_model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] sd, input int wait_n, input logic [31:0] rd);
        do_mem(op, a, sd, 1'b1, 5'd12, wait_n, rd, m_sel(op, a), m_wdata(op, sd),
               m_load(op, a, rd), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_dmem_sel", 32'(dmem_sel), 32'd0);
        check("rst_stall", 32'(stall_request), 32'd0);
        check("rst_wb_we", 32'(wb_write_enable), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        #4 reset = 1'b0;
        tick();

        // Pass-through
        drive_alu(4'd0, 1'b1, 5'd3, 32'h1234_5678);
        drive_alu(4'd9, 1'b1, 5'd5, 32'h0BAD_F00D);

        // Hand-computed directed vectors
        do_mem(4'd1, 32'h0000_1003, 32'd0, 1'b1, 5'd8, 2, 32'h80FF_0011,
               4'b1000, 32'd0, 32'hFFFF_FF80, 1'b0);
        do_mem(4'd2, 32'h0000_1003, 32'd0, 1'b1, 5'd8, 2, 32'h80FF_0011,
               4'b1000, 32'd0, 32'h0000_0080, 1'b0);
        do_mem(4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 1'b1, 5'd0, 0, 32'd0,
               4'b1100, 32'hBEEF_BEEF, 32'd0, 1'b0);
        do_misaligned(4'd5, 32'h0000_3001);
        do_mem(4'd3, 32'h0000_3002, 32'd0, 1'b1, 5'd9, 0, 32'd0,
               4'b1100, 32'd0, 32'd0, 1'b1);
        do_mem(4'd5, 32'h0000_5000, 32'd0, 1'b1, 5'd10, 0, 32'hCAFE_F00D,
               4'b1111, 32'd0, 32'hCAFE_F00D, 1'b0);
        drive_alu(4'd0, 1'b1, 5'd11, 32'h1111_2222);
        // Ack on the last timeout cycle completes normally
        do_mem(4'd4, 32'h0000_6002, 32'd0, 1'b1, 5'd13, TMO - 1, 32'h8001_7FFF,
               4'b1100, 32'd0, 32'h0000_8001, 1'b0);
        do_mem(4'd8, 32'h0000_6004, 32'h0102_0304, 1'b1, 5'd1, 1, 32'd0,
               4'b1111, 32'h0102_0304, 32'd0, 1'b0);
        do_mem(4'd3, 32'h0000_6000, 32'd0, 1'b0, 5'd2, 0, 32'h1234_F00F,
               4'b0011, 32'd0, 32'd0, 1'b0);

        // Model-driven sweep over lanes
        for (int off = 0; off < 4; off++) begin
            do_mem_model(4'd1, 32'h0000_8000 + 32'(off), 32'd0, off % 2, $urandom);
            do_mem_model(4'd2, 32'h0000_8000 + 32'(off), 32'd0, 0, $urandom);
            do_mem_model(4'd6, 32'h0000_8100 + 32'(off), $urandom, off % 3, 32'd0);
        end
        for (int off = 0; off < 4; off += 2) begin
            do_mem_model(4'd3, 32'h0000_9000 + 32'(off), 32'd0, 1, 32'h8765_89AB);
            do_mem_model(4'd4, 32'h0000_9000 + 32'(off), 32'd0, 0, $urandom);
            do_mem_model(4'd7, 32'h0000_9100 + 32'(off), $urandom, 0, 32'd0);
        end
        do_mem_model(4'd5, 32'h0000_A000, 32'd0, 3, $urandom);
        do_misaligned(4'd7, 32'h0000_7001);
        do_misaligned(4'd4, 32'h0000_7003);
        do_misaligned(4'd8, 32'h0000_7002);
        drive_alu(4'd0, 1'b0, 5'd6, 32'h7777_0000);

        // Reset asserted mid-REQ
        mem_op = 4'd5; mem_addr = 32'h0000_4000; mem_write_enable = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        e_on = 1'b0;
        check("midreq_req_before", 32'(dmem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midreq_req_async", 32'(dmem_req), 32'd0);
        check("midreq_addr_async", dmem_addr, 32'd0);
        mem_op = 4'd0; mem_write_enable = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("midreq_stall_after", 32'(stall_request), 32'd0);
        check("midreq_req_after", 32'(dmem_req), 32'd0);
        tick();
        drive_alu(4'd0, 1'b1, 5'd4, 32'hFEED_0001);
        do_mem(4'd5, 32'h0000_4000, 32'd0, 1'b1, 5'd4, 0, 32'h0F0F_0F0F,
               4'b1111, 32'd0, 32'h0F0F_0F0F, 1'b0);

        e_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
